// File: rtl/encoder_fixed_point_seq.sv
// encoder_fixed_point_seq
//   Sequential fixed-point dense layer: out[j] = act(b[j] + sum_i x[i]*w[i][j]).
//   Each output lane has one MAC that steps through the N_INPUT inputs, one input
//   per cycle. A guard-bit accumulator collects the terms, the result saturates
//   to BITSIZE bits, and a ReLU is applied when ACT=1. Vectors enter and leave
//   over valid/ready handshakes, with one transaction in flight at a time.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   x, w and b carry a vector
//   in_ready   block can accept a vector (IDLE and not in reset)
//   x          input i at [i*BITSIZE +: BITSIZE]
//   w          weight (i,j) at [(j*N_INPUT+i)*BITSIZE +: BITSIZE]
//   b          bias j at [j*BITSIZE +: BITSIZE]
//   out_valid  out and sat hold a result
//   out_ready  consumer takes the result (sampled only while holding)
//   out        result j at [j*BITSIZE +: BITSIZE]
//   sat        at least one lane saturated, reported before activation
module encoder_fixed_point_seq #(
  parameter int unsigned N_INPUT  = 9,
  parameter int unsigned M_OUTPUT = 4,
  parameter int unsigned BITSIZE  = 32,
  parameter int unsigned FRAC     = 16,
  parameter int unsigned ACT      = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_INPUT*BITSIZE-1:0]     x,
  input  logic [N_INPUT*M_OUTPUT*BITSIZE-1:0] w,
  input  logic [M_OUTPUT*BITSIZE-1:0]    b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [M_OUTPUT*BITSIZE-1:0]    out,
  output logic                           sat
);

  // Wide enough that the bias plus N_INPUT shifted products can never overflow.
  localparam int unsigned ACC_W = 2*BITSIZE - FRAC + $clog2(N_INPUT+1) + 1;
  localparam int unsigned CNT_W = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUT - 1);

  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

  state_t state, state_next;

  logic signed [BITSIZE-1:0] x_r [N_INPUT];
  logic signed [BITSIZE-1:0] w_r [M_OUTPUT][N_INPUT];
  logic signed [ACC_W-1:0]   acc [M_OUTPUT];
  logic [CNT_W-1:0]          cnt;

  logic signed [ACC_W-1:0]   prod [M_OUTPUT];
  logic signed [ACC_W-1:0]   sum  [M_OUTPUT];
  logic [BITSIZE-1:0]        lane_res [M_OUTPUT];
  logic [M_OUTPUT-1:0]       lane_sat;
  logic                      accept;
  logic                      last;

  // Full-width signed product, floored by the arithmetic shift, then
  // sign-extended (or trimmed of redundant sign bits) to the accumulator width.
  function automatic logic signed [ACC_W-1:0] mac_term(
    input logic signed [BITSIZE-1:0] a,
    input logic signed [BITSIZE-1:0] c
  );
    logic signed [2*BITSIZE-1:0] ae, ce, full;
    ae   = {{BITSIZE{a[BITSIZE-1]}}, a};
    ce   = {{BITSIZE{c[BITSIZE-1]}}, c};
    full = ae * ce;
    return ACC_W'(full >>> FRAC);
  endfunction

  assign accept = in_valid && in_ready;
  assign last   = (cnt == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = MAC;
      MAC:     if (last)      state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == HOLD);
  end

  // Per-lane MAC step, saturation and activation
  always_comb begin
    lane_sat = '0;
    for (int unsigned j = 0; j < M_OUTPUT; j++) begin
      prod[j] = mac_term(x_r[cnt], w_r[j][cnt]);
      sum[j]  = acc[j] + prod[j];
      // The value fits in BITSIZE bits iff every bit from BITSIZE-1 up is a sign copy.
      if ((&sum[j][ACC_W-1:BITSIZE-1]) || !(|sum[j][ACC_W-1:BITSIZE-1])) begin
        lane_res[j] = sum[j][BITSIZE-1:0];
      end else begin
        lane_sat[j] = 1'b1;
        lane_res[j] = sum[j][ACC_W-1] ? {1'b1, {(BITSIZE-1){1'b0}}}
                                      : {1'b0, {(BITSIZE-1){1'b1}}};
      end
      if (ACT == 1 && lane_res[j][BITSIZE-1]) lane_res[j] = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      out <= '0;
      sat <= 1'b0;
      for (int unsigned j = 0; j < M_OUTPUT; j++) acc[j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            for (int unsigned i = 0; i < N_INPUT; i++)
              x_r[i] <= x[i*BITSIZE +: BITSIZE];
            for (int unsigned j = 0; j < M_OUTPUT; j++) begin
              acc[j] <= ACC_W'($signed(b[j*BITSIZE +: BITSIZE]));
              for (int unsigned i = 0; i < N_INPUT; i++)
                w_r[j][i] <= w[(j*N_INPUT+i)*BITSIZE +: BITSIZE];
            end
          end
        end
        MAC: begin
          if (last) begin
            for (int unsigned j = 0; j < M_OUTPUT; j++)
              out[j*BITSIZE +: BITSIZE] <= lane_res[j];
            sat <= |lane_sat;
          end else begin
            for (int unsigned j = 0; j < M_OUTPUT; j++) acc[j] <= sum[j];
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_fixed_point_seq.sv
module tb_encoder_fixed_point_seq;

  localparam int N = 9;
  localparam int M = 4;
  localparam int B = 32;
  localparam int FRAC = 16;
  localparam longint MAXV = 64'sh7FFFFFFF;
  localparam longint MINV = -64'sh80000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, in_valid, out_ready;
  logic [N*B-1:0]   x;
  logic [N*M*B-1:0] w;
  logic [M*B-1:0]   b;
  logic             in_ready0, out_valid0, sat0;
  logic             in_ready1, out_valid1, sat1;
  logic [M*B-1:0]   out0, out1;

  encoder_fixed_point_seq #(.N_INPUT(N), .M_OUTPUT(M), .BITSIZE(B), .FRAC(FRAC), .ACT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .x(x), .w(w), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
    .out(out0), .sat(sat0));

  encoder_fixed_point_seq #(.N_INPUT(N), .M_OUTPUT(M), .BITSIZE(B), .FRAC(FRAC), .ACT(1)) dut_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .x(x), .w(w), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
    .out(out1), .sat(sat1));

  typedef struct {
    logic [M*B-1:0] out;
    logic           sat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   xs[N];
  int   ws[M][N];
  int   bs[M];
  int   checks = 0;
  int   failures = 0;

  function automatic exp_t model(input bit relu);
    exp_t e;
    longint acc, p;
    logic [B-1:0] r;
    e.out = '0;
    e.sat = 1'b0;
    for (int j = 0; j < M; j++) begin
      acc = longint'(bs[j]);
      for (int i = 0; i < N; i++) begin
        p = (longint'(xs[i]) * longint'(ws[j][i])) >>> FRAC;
        acc += p;
      end
      if (acc > MAXV) begin
        r = 32'h7FFFFFFF; e.sat = 1'b1;
      end else if (acc < MINV) begin
        r = 32'h80000000; e.sat = 1'b1;
      end else begin
        r = acc[31:0];
      end
      if (relu && r[31]) r = '0;
      e.out[j*B +: B] = r;
    end
    return e;
  endfunction

  function automatic int rnd_small();
    return int'($urandom_range(0, 32'h7FFFF)) - 32'h40000;
  endfunction

  task automatic fill_random(input bit wide);
    for (int i = 0; i < N; i++) xs[i] = wide ? int'($urandom) : rnd_small();
    for (int j = 0; j < M; j++) begin
      bs[j] = wide ? int'($urandom) : rnd_small();
      for (int i = 0; i < N; i++) ws[j][i] = wide ? int'($urandom) : rnd_small();
    end
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < N; i++) x[i*B +: B] = $urandom;
    for (int k = 0; k < N*M; k++) w[k*B +: B] = $urandom;
    for (int j = 0; j < M; j++) b[j*B +: B] = $urandom;
  endtask

  // Presents the current vector for one edge and records expected results;
  // returns at the falling edge just after the accepting edge.
  task automatic send();
    @(negedge clk);
    for (int i = 0; i < N; i++) x[i*B +: B] = xs[i];
    for (int j = 0; j < M; j++) begin
      b[j*B +: B] = bs[j];
      for (int i = 0; i < N; i++) w[(j*N+i)*B +: B] = ws[j][i];
    end
    in_valid = 1'b1;
    q0.push_back(model(1'b0));
    q1.push_back(model(1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    scramble_inputs();
  endtask

  task automatic wait_out(output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (!ok && n < 40) begin
      @(negedge clk);
      n++;
      ok = out_valid0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; w = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid0, in_ready0, sat0, out0, out_valid1, in_ready1} !== '0) begin
      failures++;
      $display("FAIL reset_state got ov=%b ir=%b sat=%b out=%h exp all zero",
               out_valid0, in_ready0, sat0, out0);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got ir=%b ov=%b exp ir=1 ov=0", in_ready0, out_valid0);
    end
  endtask

  task automatic test_basic();
    int n; bit ok; exp_t e0, e1;
    for (int i = 0; i < N; i++) xs[i] = 32'h00010000;
    for (int j = 0; j < M; j++) begin
      bs[j] = 32'h00004000;
      for (int i = 0; i < N; i++) ws[j][i] = 32'h00008000;
    end
    out_ready = 1'b1;
    send();
    wait_out(n, ok);
    e0 = q0.pop_front(); e1 = q1.pop_front();
    checks++;
    if (!ok || n != N) begin
      failures++;
      $display("FAIL basic_latency got ok=%0d cycles=%0d exp cycles=%0d", ok, n, N);
    end
    checks++;
    if (out0 !== {M{32'h0004C000}} || sat0 !== 1'b0) begin
      failures++;
      $display("FAIL basic_value got out=%h sat=%b exp out=%h sat=0", out0, sat0, {M{32'h0004C000}});
    end
    checks++;
    if ({out0, sat0, out1, sat1} !== {e0.out, e0.sat, e1.out, e1.sat}) begin
      failures++;
      $display("FAIL basic_model got %h/%b %h/%b exp %h/%b %h/%b",
               out0, sat0, out1, sat1, e0.out, e0.sat, e1.out, e1.sat);
    end
    @(negedge clk);
    checks++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || out0 !== {M{32'h0004C000}}) begin
      failures++;
      $display("FAIL basic_handshake got ov=%b ir=%b out=%h exp ov=0 ir=1 out held",
               out_valid0, in_ready0, out0);
    end
  endtask

  task automatic test_floor();
    int n; bit ok; exp_t e0, e1;
    for (int i = 0; i < N; i++) xs[i] = 32'hFFFFFFFF;
    for (int j = 0; j < M; j++) begin
      bs[j] = 0;
      for (int i = 0; i < N; i++) ws[j][i] = 32'h00008000;
    end
    send();
    wait_out(n, ok);
    e0 = q0.pop_front(); e1 = q1.pop_front();
    checks++;
    if (!ok || out0 !== {M{32'hFFFFFFF7}} || sat0 !== 1'b0 || out1 !== '0 || sat1 !== 1'b0) begin
      failures++;
      $display("FAIL floor_value got ok=%0d out=%h sat=%b relu=%h exp out=%h sat=0 relu=0",
               ok, out0, sat0, out1, {M{32'hFFFFFFF7}});
    end
    checks++;
    if ({out0, sat0, out1, sat1} !== {e0.out, e0.sat, e1.out, e1.sat}) begin
      failures++;
      $display("FAIL floor_model got %h/%b exp %h/%b", out0, sat0, e0.out, e0.sat);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    int n; bit ok; exp_t e0, e1;
    logic [B-1:0] xv [2];
    logic [B-1:0] ev [2];
    xv[0] = 32'h7FFFFFFF; ev[0] = 32'h7FFFFFFF;
    xv[1] = 32'h80000000; ev[1] = 32'h80000000;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < N; i++) xs[i] = int'(xv[t]);
      for (int j = 0; j < M; j++) begin
        bs[j] = 0;
        for (int i = 0; i < N; i++) ws[j][i] = 32'h7FFFFFFF;
      end
      send();
      wait_out(n, ok);
      e0 = q0.pop_front(); e1 = q1.pop_front();
      checks++;
      if (!ok || out0 !== {M{ev[t]}} || sat0 !== 1'b1 || sat1 !== 1'b1) begin
        failures++;
        $display("FAIL saturation_%0d got ok=%0d out=%h sat=%b sat_relu=%b exp out=%h sat=1",
                 t, ok, out0, sat0, sat1, {M{ev[t]}});
      end
      checks++;
      if ({out1, sat1} !== {e1.out, e1.sat} || {out0, sat0} !== {e0.out, e0.sat}) begin
        failures++;
        $display("FAIL saturation_model_%0d got relu=%h exp relu=%h", t, out1, e1.out);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mixed();
    int n; bit ok; exp_t e0, e1;
    for (int i = 0; i < N; i++) begin
      xs[i] = 32'h00010000;
      ws[0][i] = 32'h00010000;
      ws[1][i] = 32'hFFFF0000;
      ws[2][i] = 32'h00008000;
      ws[3][i] = 32'hFFFC0000;
    end
    for (int j = 0; j < M; j++) bs[j] = 0;
    send();
    wait_out(n, ok);
    e0 = q0.pop_front(); e1 = q1.pop_front();
    checks++;
    if (!ok || out0[31:0] !== 32'h00090000 || out0[63:32] !== 32'hFFF70000) begin
      failures++;
      $display("FAIL mixed_identity got ok=%0d l0=%h l1=%h exp l0=00090000 l1=fff70000",
               ok, out0[31:0], out0[63:32]);
    end
    checks++;
    if (out1[31:0] !== 32'h00090000 || out1[63:32] !== 32'h00000000) begin
      failures++;
      $display("FAIL mixed_relu got l0=%h l1=%h exp l0=00090000 l1=00000000",
               out1[31:0], out1[63:32]);
    end
    checks++;
    if ({out0, sat0, out1, sat1} !== {e0.out, e0.sat, e1.out, e1.sat}) begin
      failures++;
      $display("FAIL mixed_model got %h/%b %h/%b exp %h/%b %h/%b",
               out0, sat0, out1, sat1, e0.out, e0.sat, e1.out, e1.sat);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n; bit ok; exp_t e0, e1;
    logic [M*B-1:0] snap;
    logic snap_sat;
    int unstable;
    fill_random(1'b0);
    out_ready = 1'b0;
    send();
    wait_out(n, ok);
    e0 = q0.pop_front(); e1 = q1.pop_front();
    snap = out0; snap_sat = sat0;
    checks++;
    if (!ok || {out0, sat0, out1, sat1} !== {e0.out, e0.sat, e1.out, e1.sat}) begin
      failures++;
      $display("FAIL backpressure_value got ok=%0d out=%h sat=%b exp out=%h sat=%b",
               ok, out0, sat0, e0.out, e0.sat);
    end
    unstable = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = ~in_valid;
      scramble_inputs();
      @(negedge clk);
      if (out0 !== snap || sat0 !== snap_sat || out_valid0 !== 1'b1 || in_ready0 !== 1'b0)
        unstable++;
    end
    checks++;
    if (unstable != 0) begin
      failures++;
      $display("FAIL backpressure_hold got unstable_cycles=%0d exp 0 (last out=%h ov=%b ir=%b)",
               unstable, out0, out_valid0, in_ready0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release got ov=%b ir=%b exp ov=0 ir=1", out_valid0, in_ready0);
    end
    fill_random(1'b0);
    send();
    wait_out(n, ok);
    e0 = q0.pop_front(); e1 = q1.pop_front();
    checks++;
    if (!ok || n != N || {out0, sat0, out1, sat1} !== {e0.out, e0.sat, e1.out, e1.sat}) begin
      failures++;
      $display("FAIL backpressure_next got ok=%0d cycles=%0d out=%h exp out=%h",
               ok, n, out0, e0.out);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n; bit ok; exp_t e0, e1;
    int seen;
    fill_random(1'b0);
    out_ready = 1'b1;
    send();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid0, in_ready0, sat0, out0, out_valid1, sat1, out1} !== '0) begin
      failures++;
      $display("FAIL reset_mid_state got ov=%b ir=%b sat=%b out=%h exp all zero",
               out_valid0, in_ready0, sat0, out0);
    end
    rst = 1'b0;
    void'(q0.pop_front());
    void'(q1.pop_front());
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid0 || out_valid1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_mid_abort got out_valid_cycles=%0d exp 0", seen);
    end
    fill_random(1'b0);
    send();
    wait_out(n, ok);
    e0 = q0.pop_front(); e1 = q1.pop_front();
    checks++;
    if (!ok || n != N || {out0, sat0, out1, sat1} !== {e0.out, e0.sat, e1.out, e1.sat}) begin
      failures++;
      $display("FAIL reset_mid_fresh got ok=%0d cycles=%0d out=%h sat=%b exp out=%h sat=%b",
               ok, n, out0, sat0, e0.out, e0.sat);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n; bit ok; exp_t e0, e1;
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      fill_random(t % 3 == 2);
      send();
      wait_out(n, ok);
      e0 = q0.pop_front(); e1 = q1.pop_front();
      checks++;
      if (!ok || n != N || {out0, sat0, out1, sat1} !== {e0.out, e0.sat, e1.out, e1.sat}) begin
        failures++;
        $display("FAIL back_to_back_%0d got ok=%0d cycles=%0d out=%h sat=%b relu=%h exp out=%h sat=%b relu=%h",
                 t, ok, n, out0, sat0, out1, e0.out, e0.sat, e1.out);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_floor();
    test_saturation();
    test_mixed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
